// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states,
// byte-enable patterns and request legality check.
package lsu_pkg;

    // RV32I funct3 width codes (loads and stores share the low three)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-enable patterns for lane 0; shifted by addr[1:0] for sub-word stores
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Unsupported width code or an address not aligned to the access size
    function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                         input logic [1:0] lo);
        logic bad_code;
        logic misalign;
        bad_code = we ? (f3 > F3_W) : (f3 == 3'b011 || f3[2:1] == 2'b11);
        case (f3[1:0])
            2'b01:   misalign = lo[0];
            2'b10:   misalign = (lo != 2'b00);
            default: misalign = 1'b0;
        endcase
        return bad_code | misalign;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data replication with byte enables, and load
// lane extraction with sign/zero extension. Purely combinational.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_lo,
    input  logic [2:0]  st_f3,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  logic [1:0]  ld_lo,
    input  logic [2:0]  ld_f3,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_sh;

    // Replicate the store operand to every lane it could land in
    always_comb begin
        case (st_f3[1:0])
            2'b00: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = BE_BYTE << st_lo;
            end
            2'b01: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = BE_HALF << st_lo;
            end
            default: begin
                st_wdata = st_data;
                st_be    = BE_WORD;
            end
        endcase
    end

    assign ld_sh = ld_word >> {ld_lo, 3'b000};

    // Bring the addressed lane down to bit 0, then extend
    always_comb begin
        case (ld_f3)
            F3_B:    ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
            F3_H:    ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
            F3_BU:   ld_data = {24'b0, ld_sh[7:0]};
            F3_HU:   ld_data = {16'b0, ld_sh[15:0]};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one blocking transaction on the data-memory port per
// accepted request, with a bounded wait on mem_ack.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [1:0]  lat_lo;
    logic [2:0]  lat_f3;
    logic        lat_we;
    logic [7:0]  cnt;
    logic [31:0] fmt_wdata, ld_data;
    logic [3:0]  fmt_be;
    logic        accept, illegal, timeout_hit;

    assign req_ready   = (state == IDLE);
    assign accept      = req_valid & req_ready;
    assign illegal     = req_illegal(req_we, req_funct3, req_addr[1:0]);
    assign timeout_hit = (cnt == TMAX);

    lsu_lane_align u_align (
        .st_lo    (req_addr[1:0]),
        .st_f3    (req_funct3),
        .st_data  (req_wdata),
        .st_wdata (fmt_wdata),
        .st_be    (fmt_be),
        .ld_lo    (lat_lo),
        .ld_f3    (lat_f3),
        .ld_word  (mem_rdata),
        .ld_data  (ld_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state; ack is checked before timeout so a coincident ack wins
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = illegal ? RESP : WAIT;
            WAIT:    if (mem_ack || timeout_hit) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered memory-port and response outputs plus request latches
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            lat_lo     <= '0;
            lat_f3     <= '0;
            lat_we     <= 1'b0;
            cnt        <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (state)
                IDLE: if (accept) begin
                    lat_lo <= req_addr[1:0];
                    lat_f3 <= req_funct3;
                    lat_we <= req_we;
                    cnt    <= '0;
                    if (illegal) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_wdata <= req_we ? fmt_wdata : '0;
                        mem_be    <= req_we ? fmt_be : BE_WORD;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (mem_ack || timeout_hit) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_be     <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= !mem_ack;
                        resp_rdata <= (mem_ack && !lat_we) ? ld_data : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu with TIMEOUT=4.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    // Observations recorded by run_op
    logic        m_req, m_we, m_rdy, r_err, rdy_after, rv_after;
    logic [31:0] m_addr, m_wdata, r_rdata;
    logic [3:0]  m_be;
    int          req_cnt, resp_at;

    lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Drive one request; ack on WAIT cycle ack_at (0 = never). Cycle 1 is
    // the first cycle after the accept edge. Records what was observed.
    task automatic run_op(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_at);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = a; req_wdata = wd; mem_rdata = rd;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
        req_funct3 = 3'b111; req_we = ~we;
        m_req = mem_req; m_we = mem_we; m_be = mem_be; m_rdy = req_ready;
        m_addr = mem_addr; m_wdata = mem_wdata;
        req_cnt = 0; resp_at = 0; r_err = 1'bx; r_rdata = 'x;
        for (int c = 1; c <= 20; c++) begin
            if (mem_req) req_cnt++;
            if (resp_valid) begin
                resp_at = c; r_err = resp_err; r_rdata = resp_rdata;
                break;
            end
            mem_ack = (c == ack_at);
            @(negedge clk);
            mem_ack = 1'b0;
        end
        @(negedge clk);
        rdy_after = req_ready; rv_after = resp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_memreq got=%b%b exp=00", mem_req, mem_we); end
        checks++; if (mem_be !== 4'h0) begin errors++; $display("FAIL rst_be got=%h exp=0", mem_be); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_addr_wdata got=%h/%h exp=0/0", mem_addr, mem_wdata); end
        checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp got=%b %b %h exp=0 0 0", resp_valid, resp_err, resp_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_sw_lw();
        run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 3);
        checks++; if (m_req !== 1'b1 || m_we !== 1'b1) begin errors++; $display("FAIL sw_req got=%b%b exp=11", m_req, m_we); end
        checks++; if (m_rdy !== 1'b0) begin errors++; $display("FAIL sw_busy_ready got=%b exp=0", m_rdy); end
        checks++; if (m_be !== 4'b1111) begin errors++; $display("FAIL sw_be got=%b exp=1111", m_be); end
        checks++; if (m_addr !== 32'h100) begin errors++; $display("FAIL sw_addr got=%h exp=100", m_addr); end
        checks++; if (m_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got=%h exp=deadbeef", m_wdata); end
        checks++; if (resp_at !== 4) begin errors++; $display("FAIL sw_resp_cycle got=%0d exp=4", resp_at); end
        checks++; if (r_err !== 1'b0 || r_rdata !== 32'h0) begin errors++; $display("FAIL sw_resp got=%b %h exp=0 0", r_err, r_rdata); end
        checks++; if (rdy_after !== 1'b1 || rv_after !== 1'b0) begin errors++; $display("FAIL sw_after got=%b%b exp=10", rdy_after, rv_after); end
        checks++; if (req_cnt !== 3) begin errors++; $display("FAIL sw_req_cycles got=%0d exp=3", req_cnt); end
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        checks++; if (m_we !== 1'b0 || m_be !== 4'b1111) begin errors++; $display("FAIL lw_we_be got=%b %b exp=0 1111", m_we, m_be); end
        checks++; if (resp_at !== 2 || r_err !== 1'b0) begin errors++; $display("FAIL lw_resp got=%0d %b exp=2 0", resp_at, r_err); end
        checks++; if (r_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got=%h exp=deadbeef", r_rdata); end
    endtask

    task automatic test_bytes();
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 2);
        checks++; if (r_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_103 got=%h exp=ffffff80", r_rdata); end
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01, 1);
        checks++; if (r_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_103 got=%h exp=00000080", r_rdata); end
        run_op(1'b0, 3'b000, 32'h101, 32'h0, 32'h80FF7F01, 1);
        checks++; if (r_rdata !== 32'h0000007F) begin errors++; $display("FAIL lb_101 got=%h exp=0000007f", r_rdata); end
        run_op(1'b0, 3'b000, 32'h102, 32'h0, 32'h80FF7F01, 1);
        checks++; if (r_rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb_102 got=%h exp=ffffffff", r_rdata); end
        run_op(1'b1, 3'b000, 32'h102, 32'h000000AB, 32'h0, 1);
        checks++; if (m_be !== 4'b0100) begin errors++; $display("FAIL sb_be got=%b exp=0100", m_be); end
        checks++; if (m_wdata !== 32'hABABABAB || m_addr !== 32'h100) begin errors++; $display("FAIL sb_wdata_addr got=%h %h exp=abababab 100", m_wdata, m_addr); end
    endtask

    task automatic test_half();
        run_op(1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 1);
        checks++; if (r_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_102 got=%h exp=ffff8001", r_rdata); end
        run_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h80017FFF, 1);
        checks++; if (r_rdata !== 32'h00008001) begin errors++; $display("FAIL lhu_102 got=%h exp=00008001", r_rdata); end
        run_op(1'b0, 3'b001, 32'h100, 32'h0, 32'h80017FFF, 1);
        checks++; if (r_rdata !== 32'h00007FFF) begin errors++; $display("FAIL lh_100 got=%h exp=00007fff", r_rdata); end
        run_op(1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 1);
        checks++; if (m_be !== 4'b1100 || m_wdata !== 32'h12341234) begin errors++; $display("FAIL sh_be_wdata got=%b %h exp=1100 12341234", m_be, m_wdata); end
    endtask

    task automatic test_illegal();
        logic [2:0] f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b011};
        logic       wes [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] as [4] = '{32'h102, 32'h101, 32'h100, 32'h100};
        for (int i = 0; i < 4; i++) begin
            run_op(wes[i], f3s[i], as[i], 32'h1234_5678, 32'hCAFE_F00D, 1);
            checks++; if (resp_at !== 1 || r_err !== 1'b1 || r_rdata !== 32'h0) begin errors++; $display("FAIL illegal_%0d_resp got=%0d %b %h exp=1 1 0", i, resp_at, r_err, r_rdata); end
            checks++; if (m_req !== 1'b0 || req_cnt !== 0) begin errors++; $display("FAIL illegal_%0d_memreq got=%b %0d exp=0 0", i, m_req, req_cnt); end
        end
    endtask

    task automatic test_timeout();
        run_op(1'b0, 3'b010, 32'h200, 32'h0, 32'h1111_2222, 0);
        checks++; if (req_cnt !== 4) begin errors++; $display("FAIL to_req_cycles got=%0d exp=4", req_cnt); end
        checks++; if (resp_at !== 5 || r_err !== 1'b1 || r_rdata !== 32'h0) begin errors++; $display("FAIL to_resp got=%0d %b %h exp=5 1 0", resp_at, r_err, r_rdata); end
        run_op(1'b0, 3'b010, 32'h200, 32'h0, 32'h1111_2222, 4);
        checks++; if (resp_at !== 5 || r_err !== 1'b0 || r_rdata !== 32'h1111_2222) begin errors++; $display("FAIL to_ack_last got=%0d %b %h exp=5 0 11112222", resp_at, r_err, r_rdata); end
    endtask

    task automatic test_reset_mid();
        int stray;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (mem_req !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL midrst_state got=%b %b exp=0 1", mem_req, req_ready); end
        mem_ack = 1'b1;
        stray = 0;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (3) begin
            if (resp_valid) stray++;
            @(negedge clk);
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL midrst_stray_ack got=%0d exp=0", stray); end
        run_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h0BAD_F00D, 2);
        checks++; if (resp_at !== 3 || r_err !== 1'b0 || r_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL midrst_lw got=%0d %b %h exp=3 0 0badf00d", resp_at, r_err, r_rdata); end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_bytes();
        test_half();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
